gb_cpu_sequencer: RTL and testbench

M-cycle sequencer for the Game Boy CPU core. Owns the instruction register (IR) and the CB-prefix flag, and feeds them to `gb_cpu_decoder`. Steps the returned `schedule_t` one M-cycle at a time, using four T-cycles per M-cycle, and presents the active control word to the datapath. Handles the overlapped opcode fetch, conditional early exit, HALT, hard lock and, optionally, interrupt dispatch.

---
 rtl/gb_cpu_decoder_pkg.sv | 77 +++++++
 rtl/gb_cpu_tcycle_counter.sv | 24 ++
 rtl/gb_cpu_sequencer.sv | 154 +++++++++++++++
 tb/tb_gb_cpu_sequencer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gb_cpu_decoder_pkg.sv
// Shared decoder/sequencer types: M-cycle control word, instruction schedule,
// sequencer states and opcode constants. GB_CPU_SEQ_IRQ_EN adds the IRQ state.
package gb_cpu_decoder_pkg;

    typedef struct packed {
        logic       fetch;
        logic       mem_rd;
        logic       mem_wr;
        logic [2:0] addr_sel;
        logic [3:0] alu_op;
        logic [3:0] reg_wr;
    } mcycle_ctrl_t;

    localparam int unsigned MAX_MCYCLES = 6;

    typedef struct packed {
        logic [2:0]                        num_cycles;
        logic                              cond_en;
        logic [2:0]                        cond_cycle;
        mcycle_ctrl_t [0:MAX_MCYCLES-1]    mcycles;
    } schedule_t;

    typedef enum logic [2:0] {
        FETCH,
        EXEC,
        CB_FETCH,
        HALT,
        LOCK
`ifdef GB_CPU_SEQ_IRQ_EN
        , IRQ
`endif
    } seq_state_t;

    localparam logic [7:0] CB_PREFIX   = 8'hCB;
    localparam logic [7:0] HALT_OPCODE = 8'h76;

    localparam int unsigned N_HARD_LOCK = 11;
    localparam logic [7:0] HARD_LOCK_OPCODES [N_HARD_LOCK] = '{
        8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB,
        8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD
    };

    localparam logic [2:0] ADDR_PC      = 3'd0;
    localparam logic [2:0] ADDR_SP      = 3'd2;
    localparam logic [2:0] ADDR_IRQ_VEC = 3'd5;

    localparam mcycle_ctrl_t FETCH_ONLY_CTRL = '{
        fetch: 1'b1, mem_rd: 1'b1, mem_wr: 1'b0,
        addr_sel: ADDR_PC, alu_op: 4'd0, reg_wr: 4'd0
    };

    // Dispatch: idle, SP--, push PCh, push PCl, fetch from the vector.
    localparam mcycle_ctrl_t [0:4] IRQ_SCHEDULE = '{
        '{1'b0, 1'b0, 1'b0, ADDR_PC,      4'd0, 4'd0},
        '{1'b0, 1'b0, 1'b0, ADDR_SP,      4'd0, 4'hA},
        '{1'b0, 1'b0, 1'b1, ADDR_SP,      4'd0, 4'hA},
        '{1'b0, 1'b0, 1'b1, ADDR_SP,      4'd0, 4'd0},
        '{1'b1, 1'b1, 1'b0, ADDR_IRQ_VEC, 4'd0, 4'd0}
    };

    function automatic logic is_hard_lock(input logic [7:0] op);
        logic hit;
        hit = 1'b0;
        for (int unsigned i = 0; i < N_HARD_LOCK; i++) begin
            if (op == HARD_LOCK_OPCODES[i]) hit = 1'b1;
        end
        return hit;
    endfunction

    // A zero-length schedule runs as a single fetch; keep the index inside mcycles.
    function automatic logic [2:0] eff_cycles(input logic [2:0] n);
        if (n == 3'd0) return 3'd1;
        if (n > 3'd6)  return 3'd6;
        return n;
    endfunction

endpackage

// File: rtl/gb_cpu_tcycle_counter.sv
// Four-phase T-cycle counter; m_end marks T3, hold parks the count at 0.
module gb_cpu_tcycle_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hold,
    output logic [1:0] t_cycle,
    output logic       m_end
);

    logic [1:0] t_q, t_d;

    always_comb begin
        t_d = hold ? 2'd0 : t_q + 2'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) t_q <= '0;
        else        t_q <= t_d;
    end

    assign t_cycle = t_q;
    assign m_end   = ~hold & (t_q == 2'd3);

endmodule

// File: rtl/gb_cpu_sequencer.sv
// M-cycle sequencer: owns IR/CB flag, steps the decoder schedule, handles
// overlapped fetch, HALT and LOCK. GB_CPU_SEQ_IRQ_EN enables interrupt dispatch.
module gb_cpu_sequencer
    import gb_cpu_decoder_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  schedule_t    schedule,
    input  logic [7:0]   data_in,
    input  logic         cond_met,
    input  logic         irq_pending,
    input  logic         ime,
    output logic [7:0]   ir_opcode,
    output logic         ir_cb,
    output mcycle_ctrl_t ctrl,
    output logic [1:0]   t_cycle,
    output logic [2:0]   m_cycle,
    output logic         fetch,
    output logic         irq_ack,
    output logic         halted,
    output logic         locked
);

    seq_state_t state_q, state_d;
    logic [7:0] ir_opcode_q, ir_opcode_d;
    logic       ir_cb_q, ir_cb_d;
    logic [2:0] m_cycle_q, m_cycle_d;
    logic [2:0] n_cyc, last_m;
    logic [1:0] t_w;
    logic       m_end, lock_hold, take_irq;

    assign lock_hold = (state_q == LOCK);

    gb_cpu_tcycle_counter u_tcnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .hold    (lock_hold),
        .t_cycle (t_w),
        .m_end   (m_end)
    );

    assign n_cyc  = eff_cycles(schedule.num_cycles);
    assign last_m = n_cyc - 3'd1;

`ifdef GB_CPU_SEQ_IRQ_EN
    // A CB opcode byte still belongs to its prefix, so dispatch waits for it.
    assign take_irq = ime & irq_pending & (data_in != CB_PREFIX) & (state_q != CB_FETCH);
`else
    logic unused_ime;
    assign unused_ime = ime;
    assign take_irq   = 1'b0;
`endif

    always_comb begin
        ctrl    = '0;
        fetch   = 1'b0;
        halted  = 1'b0;
        locked  = 1'b0;
        irq_ack = 1'b0;
        case (state_q)
            FETCH, CB_FETCH: begin
                ctrl  = FETCH_ONLY_CTRL;
                fetch = 1'b1;
            end
            EXEC: begin
                ctrl  = schedule.mcycles[m_cycle_q];
                fetch = (m_cycle_q == last_m);
            end
            HALT: halted = 1'b1;
            LOCK: locked = 1'b1;
`ifdef GB_CPU_SEQ_IRQ_EN
            IRQ: begin
                ctrl    = IRQ_SCHEDULE[m_cycle_q];
                fetch   = (m_cycle_q == 3'd4);
                irq_ack = (m_cycle_q == 3'd0) & (t_w == 2'd0);
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        ir_opcode_d = ir_opcode_q;
        ir_cb_d     = ir_cb_q;
        m_cycle_d   = m_cycle_q;
        if (m_end) begin
            if (fetch) begin
                m_cycle_d = '0;
                if (take_irq) begin
`ifdef GB_CPU_SEQ_IRQ_EN
                    state_d = IRQ;
                    ir_cb_d = 1'b0;
`endif
                end else begin
                    ir_opcode_d = data_in;
                    if (state_q == CB_FETCH) begin
                        state_d = EXEC;
                    end else if (data_in == CB_PREFIX && !ir_cb_q) begin
                        state_d = CB_FETCH;
                        ir_cb_d = 1'b1;
                    end else begin
                        ir_cb_d = 1'b0;
                        if (data_in == HALT_OPCODE)    state_d = HALT;
                        else if (is_hard_lock(data_in)) state_d = LOCK;
                        else                           state_d = EXEC;
                    end
                end
            end else begin
                case (state_q)
                    EXEC: begin
                        if (schedule.cond_en && m_cycle_q == schedule.cond_cycle && !cond_met)
                            m_cycle_d = last_m;
                        else
                            m_cycle_d = m_cycle_q + 3'd1;
                    end
                    HALT: begin
                        if (irq_pending) begin
`ifdef GB_CPU_SEQ_IRQ_EN
                            state_d = ime ? IRQ : FETCH;
`else
                            state_d = FETCH;
`endif
                        end
                    end
`ifdef GB_CPU_SEQ_IRQ_EN
                    IRQ: m_cycle_d = m_cycle_q + 3'd1;
`endif
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FETCH;
            ir_opcode_q <= '0;
            ir_cb_q     <= 1'b0;
            m_cycle_q   <= '0;
        end else begin
            state_q     <= state_d;
            ir_opcode_q <= ir_opcode_d;
            ir_cb_q     <= ir_cb_d;
            m_cycle_q   <= m_cycle_d;
        end
    end

    assign ir_opcode = ir_opcode_q;
    assign ir_cb     = ir_cb_q;
    assign m_cycle   = m_cycle_q;
    assign t_cycle   = t_w;

endmodule

// File: tb/tb_gb_cpu_sequencer.sv
// Scoreboard bench for gb_cpu_sequencer: an M-cycle level instruction model
// queues expected outputs; a monitor compares every T-cycle against the head.
module tb_gb_cpu_sequencer;
    import gb_cpu_decoder_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    schedule_t    schedule;
    logic [7:0]   data_in = 8'h00;
    logic         cond_met = 1'b0;
    logic         irq_pending = 1'b0;
    logic         ime = 1'b0;
    logic [7:0]   ir_opcode;
    logic         ir_cb;
    mcycle_ctrl_t ctrl;
    logic [1:0]   t_cycle;
    logic [2:0]   m_cycle;
    logic         fetch, irq_ack, halted, locked;

    gb_cpu_sequencer dut (
        .clk(clk), .rst_n(rst_n), .schedule(schedule), .data_in(data_in),
        .cond_met(cond_met), .irq_pending(irq_pending), .ime(ime),
        .ir_opcode(ir_opcode), .ir_cb(ir_cb), .ctrl(ctrl), .t_cycle(t_cycle),
        .m_cycle(m_cycle), .fetch(fetch), .irq_ack(irq_ack), .halted(halted),
        .locked(locked)
    );

    always #5 clk = ~clk;

    // Stand-in decoder: a table indexed by {ir_cb, ir_opcode}.
    schedule_t sched_tab [512];
    assign schedule = sched_tab[{ir_cb, ir_opcode}];

    localparam logic [13:0] TB_FETCH_CTRL = 14'h3000;  // fetch + mem_rd, PC address
    localparam logic [7:0]  TB_LOCK_OPS [11] = '{
        8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB, 8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD
    };

    typedef struct {
        logic [2:0]  m;
        logic [13:0] ctrl;
        logic        fetch, halted, locked, cb;
        logic [7:0]  op;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    bit         md_halt, md_lock, md_solo, md_cbf, md_cb;
    int         md_idx;
    logic [7:0] md_op;

    function automatic bit tb_is_lock(input logic [7:0] d);
        for (int i = 0; i < 11; i++) if (TB_LOCK_OPS[i] == d) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int eff_n(input int n);
        return (n == 0) ? 1 : n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void mdl_reset();
        md_halt = 0; md_lock = 0; md_solo = 1; md_cbf = 0; md_cb = 0;
        md_idx = 0; md_op = 8'h00;
    endfunction

    function automatic bit mdl_is_fetch();
        schedule_t s;
        if (md_lock || md_halt) return 1'b0;
        if (md_solo || md_cbf) return 1'b1;
        s = sched_tab[{md_cb, md_op}];
        return md_idx == eff_n(int'(s.num_cycles)) - 1;
    endfunction

    // One M-cycle of the instruction-level model; returns what the DUT should show.
    task automatic mdl_step(input logic [7:0] d, input bit cm, input bit irq, output exp_t e);
        schedule_t s;
        int n;
        bit f;
        e.op = md_op; e.cb = md_cb; e.m = '0; e.ctrl = '0;
        e.fetch = 0; e.halted = 0; e.locked = 0;
        f = 0;
        if (md_lock) begin
            e.locked = 1;
        end else if (md_halt) begin
            e.halted = 1;
            if (irq) begin md_halt = 0; md_solo = 1; end
        end else if (md_solo || md_cbf) begin
            e.ctrl = TB_FETCH_CTRL; e.fetch = 1; f = 1;
        end else begin
            s = sched_tab[{md_cb, md_op}];
            n = eff_n(int'(s.num_cycles));
            e.m = 3'(md_idx);
            e.ctrl = s.mcycles[md_idx];
            e.fetch = (md_idx == n - 1);
            if (e.fetch) f = 1;
            else if (s.cond_en && md_idx == int'(s.cond_cycle) && !cm) md_idx = n - 1;
            else md_idx++;
        end
        if (f) begin
            md_idx = 0;
            md_op = d;
            md_solo = 0;
            if (md_cbf) begin
                md_cbf = 0;
            end else if (d == 8'hCB && !md_cb) begin
                md_cb = 1; md_cbf = 1;
            end else begin
                md_cb = 0;
                if (d == 8'h76) md_halt = 1;
                else if (tb_is_lock(d)) md_lock = 1;
            end
        end
    endtask

    // mode 0/1 = constant value, 2 = random
    task automatic run_mc(input logic [7:0] d, input int cm_mode, input int irq_mode, input int nneg);
        bit cm, irq;
        exp_t e;
        cm  = (cm_mode == 2) ? ($urandom_range(0, 1) == 1) : (cm_mode == 1);
        irq = (irq_mode == 2) ? ($urandom_range(0, 3) == 0) : (irq_mode == 1);
        mdl_step(d, cm, irq, e);
        q.push_back(e);
        data_in = d; cond_met = cm; irq_pending = irq;
        repeat (nneg) @(negedge clk);
    endtask

    task automatic run_instr(input logic [7:0] d, input int cm_mode, input int irq_mode);
        bit f;
        for (int i = 0; i < 64; i++) begin
            f = mdl_is_fetch();
            run_mc(d, cm_mode, irq_mode, 4);
            if (f) return;
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ir_opcode"}, 32'(ir_opcode), 32'h00);
        chk({tag, "_ir_cb"},     32'(ir_cb), 32'h0);
        chk({tag, "_t_cycle"},   32'(t_cycle), 32'h0);
        chk({tag, "_m_cycle"},   32'(m_cycle), 32'h0);
        chk({tag, "_ctrl"},      32'(ctrl), 32'(TB_FETCH_CTRL));
        chk({tag, "_fetch"},     32'(fetch), 32'h1);
        chk({tag, "_irq_ack"},   32'(irq_ack), 32'h0);
        chk({tag, "_halted"},    32'(halted), 32'h0);
        chk({tag, "_locked"},    32'(locked), 32'h0);
    endtask

    // Monitor: T0 of each M-cycle is skipped (its record is queued mid-T0).
    int pcount = 0;
    initial begin
        exp_t e;
        int ph;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                pcount = 0;
            end else begin
                pcount++;
                ph = pcount % 4;
                if (ph != 0) begin
                    if (q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL queue_empty: no expected record at %0t", $time);
                    end else begin
                        e = q[0];
                        chk("t_cycle",   32'(t_cycle), e.locked ? 32'd0 : 32'(ph));
                        chk("m_cycle",   32'(m_cycle), 32'(e.m));
                        chk("ctrl",      32'(ctrl), 32'(e.ctrl));
                        chk("fetch",     32'(fetch), 32'(e.fetch));
                        chk("halted",    32'(halted), 32'(e.halted));
                        chk("locked",    32'(locked), 32'(e.locked));
                        chk("ir_opcode", 32'(ir_opcode), 32'(e.op));
                        chk("ir_cb",     32'(ir_cb), 32'(e.cb));
                        chk("irq_ack",   32'(irq_ack), 32'h0);
                        if (ph == 3) void'(q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete, %0d checks %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        logic [7:0]  d;
        logic [31:0] r;
        int n;
        for (int i = 0; i < 512; i++) begin
            n = $urandom_range(1, 6);
            sched_tab[i].num_cycles = 3'(n);
            sched_tab[i].cond_en    = (n >= 2) && ($urandom_range(0, 1) == 1);
            sched_tab[i].cond_cycle = (n >= 2) ? 3'($urandom_range(0, n - 2)) : 3'd0;
            for (int j = 0; j < 6; j++) begin
                r = $urandom;
                sched_tab[i].mcycles[j] = r[13:0];
            end
        end
        sched_tab[9'h000].num_cycles = 3'd1; sched_tab[9'h000].cond_en = 1'b0;
        sched_tab[9'h086].num_cycles = 3'd2; sched_tab[9'h086].cond_en = 1'b0;
        sched_tab[9'h020].num_cycles = 3'd3; sched_tab[9'h020].cond_en = 1'b1;
        sched_tab[9'h020].cond_cycle = 3'd0;
        sched_tab[9'h001].num_cycles = 3'd0; sched_tab[9'h001].cond_en = 1'b0;
        sched_tab[9'h137].num_cycles = 3'd2; sched_tab[9'h137].cond_en = 1'b0;

        repeat (3) @(negedge clk);
        chk_reset("reset");
        mdl_reset();
        rst_n = 1'b1;

        repeat (3) run_mc(8'h00, 0, 0, 4);
        run_instr(8'h86, 0, 0);
        run_instr(8'h00, 0, 0);
        run_instr(8'h20, 0, 0);
        run_instr(8'h00, 0, 0);
        run_instr(8'h20, 1, 0);
        run_instr(8'h00, 1, 0);
        run_instr(8'hCB, 0, 0);
        run_instr(8'h37, 0, 0);
        run_instr(8'h00, 0, 0);
        run_instr(8'h00, 0, 0);
        run_instr(8'h01, 0, 0);
        run_instr(8'h00, 0, 0);

        for (int i = 0; i < 300; i++) begin
            d = 8'($urandom);
            if (tb_is_lock(d)) d = 8'h00;
            if ($urandom_range(0, 15) == 0) d = 8'h76;
            if ($urandom_range(0, 15) == 0) d = 8'hCB;
            run_instr(d, 2, 2);
        end
        run_instr(8'h00, 0, 1);

        run_instr(8'h76, 2, 0);
        repeat (10) run_mc(8'h00, 2, 0, 4);
        run_mc(8'h00, 2, 1, 4);
        run_instr(8'h00, 0, 0);
        run_instr(8'h00, 0, 0);
        run_instr(8'h76, 0, 1);
        run_instr(8'h00, 0, 1);
        run_instr(8'h00, 0, 0);

        run_instr(8'hD3, 2, 2);
        repeat (20) run_mc(8'($urandom), 2, 2, 4);
        run_mc(8'h00, 2, 2, 2);
        rst_n = 1'b0;
        q.delete();
        #1;
        chk_reset("midrst");
        repeat (2) @(negedge clk);
        mdl_reset();
        rst_n = 1'b1;
        repeat (3) run_instr(8'h00, 0, 0);
        run_instr(8'h86, 0, 0);
        run_instr(8'h00, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
